darktimer_nch: RTL and testbench



---
 rtl/darktimer_nch.sv | 212 +++++++++++++++++++++
 tb/tb_darktimer_nch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/darktimer_nch.sv
// Multi-channel down-counter timer with a shared prescaler, pending/overrun flags and IRQ outputs.
// Define DARKTIMER_TSTAMP_EN to add a 64-bit cycle timestamp readable at 0x08/0x0C.
module darktimer_nch #(
  parameter int NCH      = 4,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 49,
  parameter int AW       = 8
) (
  input  logic           CLK,
  input  logic           RES,
  input  logic           RD,
  input  logic           WR,
  input  logic [3:0]     BE,
  input  logic [AW-1:0]  ADDR,
  input  logic [31:0]    DATAI,
  output logic [31:0]    DATAO,
  output logic           RACK,
  output logic           IRQ,
  output logic [NCH-1:0] IRQV
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int GW = AW - 4;

  logic [GW-1:0]    grp;
  logic [1:0]       off;
  logic             top_sel, status_wr, presc_wr, tick;
  logic [NCH-1:0]   ch_sel, ctrl_wr, reload_wr, ack, evt;
  logic [31:0]      presc, presc_cnt, rdata;
  state_t           state [NCH];
  state_t           state_nxt [NCH];
  logic [WIDTH-1:0] reload [NCH];
  logic [WIDTH-1:0] reload_nxt [NCH];
  logic [WIDTH-1:0] count [NCH];
  logic [WIDTH-1:0] count_nxt [NCH];
  logic [NCH-1:0]   periodic, periodic_nxt, irq_en, irq_en_nxt;
  logic [NCH-1:0]   pending, pending_nxt, overrun, overrun_nxt;
  logic             unused_addr_bits;

  assign grp              = ADDR[AW-1:4];
  assign off              = ADDR[3:2];
  assign top_sel          = (grp == '0);
  assign status_wr        = WR && top_sel && (off == 2'd0) && BE[0];
  assign presc_wr         = WR && top_sel && (off == 2'd1);
  assign tick             = (presc_cnt == 32'd0);
  assign unused_addr_bits = ^ADDR[1:0];

  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++)
      if (be[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    return merged;
  endfunction

  always_comb begin
    ch_sel    = '0;
    ctrl_wr   = '0;
    reload_wr = '0;
    ack       = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_sel[k]    = (32'(grp) == 32'(k + 1));
      ctrl_wr[k]   = WR && BE[0] && ch_sel[k] && (off == 2'd0);
      reload_wr[k] = WR && ch_sel[k] && (off == 2'd1);
      ack[k]       = status_wr && DATAI[k];
    end
  end

  // A disabling CTRL write beats a tick in the same cycle; an event beats an ack for pending,
  // while the ack still clears overrun.
  always_comb begin
    evt = '0;
    for (int k = 0; k < NCH; k++) begin
      state_nxt[k]    = state[k];
      count_nxt[k]    = count[k];
      reload_nxt[k]   = reload[k];
      periodic_nxt[k] = periodic[k];
      irq_en_nxt[k]   = irq_en[k];
      pending_nxt[k]  = pending[k];
      overrun_nxt[k]  = overrun[k];
      if (reload_wr[k])
        reload_nxt[k] = WIDTH'(merge_be(32'(reload[k]), DATAI, BE));
      if (ctrl_wr[k]) begin
        periodic_nxt[k] = DATAI[1];
        irq_en_nxt[k]   = DATAI[2];
      end
      if (ctrl_wr[k] && !DATAI[0]) begin
        state_nxt[k] = IDLE;
      end else if (ctrl_wr[k] && state[k] == IDLE) begin
        state_nxt[k] = RUN;
        count_nxt[k] = reload[k];
      end else if (state[k] == RUN && tick) begin
        if (count[k] != '0) begin
          count_nxt[k] = count[k] - WIDTH'(1);
        end else begin
          evt[k] = 1'b1;
          if (periodic[k]) count_nxt[k] = reload[k];
          else             state_nxt[k] = IDLE;
        end
      end
      if (evt[k])      pending_nxt[k] = 1'b1;
      else if (ack[k]) pending_nxt[k] = 1'b0;
      if (ack[k])                      overrun_nxt[k] = 1'b0;
      else if (evt[k] && pending[k])   overrun_nxt[k] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      for (int k = 0; k < NCH; k++) begin
        state[k]  <= IDLE;
        count[k]  <= '0;
        reload[k] <= '0;
      end
      periodic <= '0;
      irq_en   <= '0;
      pending  <= '0;
      overrun  <= '0;
      IRQV     <= '0;
      IRQ      <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        state[k]  <= state_nxt[k];
        count[k]  <= count_nxt[k];
        reload[k] <= reload_nxt[k];
      end
      periodic <= periodic_nxt;
      irq_en   <= irq_en_nxt;
      pending  <= pending_nxt;
      overrun  <= overrun_nxt;
      IRQV     <= pending & irq_en;
      IRQ      <= |(pending & irq_en);
    end
  end

  // Writing PRESC only changes the value loaded at the next underflow.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      presc     <= 32'(PRESCALE);
      presc_cnt <= 32'(PRESCALE);
    end else begin
      if (presc_wr) presc <= merge_be(presc, DATAI, BE);
      presc_cnt <= tick ? presc : presc_cnt - 32'd1;
    end
  end

`ifdef DARKTIMER_TSTAMP_EN
  logic [63:0] tstamp;
  logic [31:0] ts_shadow;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      tstamp    <= '0;
      ts_shadow <= '0;
    end else begin
      tstamp <= tstamp + 64'd1;
      if (RD && top_sel && off == 2'd2) ts_shadow <= tstamp[63:32];
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (top_sel) begin
      case (off)
        2'd0: begin
          rdata[NCH-1:0]   = pending;
          rdata[8 +: NCH]  = overrun;
        end
        2'd1: rdata = presc;
        2'd2: begin
`ifdef DARKTIMER_TSTAMP_EN
          rdata = tstamp[31:0];
`else
          rdata = '0;
`endif
        end
        2'd3: begin
`ifdef DARKTIMER_TSTAMP_EN
          rdata = ts_shadow;
`else
          rdata = '0;
`endif
        end
      endcase
    end
    for (int k = 0; k < NCH; k++) begin
      if (ch_sel[k]) begin
        case (off)
          2'd0:    rdata = {29'd0, irq_en[k], periodic[k], state[k] == RUN};
          2'd1:    rdata = 32'(reload[k]);
          2'd2:    rdata = 32'(count[k]);
          default: rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      DATAO <= '0;
      RACK  <= 1'b0;
    end else begin
      RACK <= RD;
      if (RD) DATAO <= rdata;
    end
  end

endmodule

// File: tb/tb_darktimer_nch.sv
// Directed bench for darktimer_nch: register access, prescaler, periodic/one-shot channels,
// pending/overrun handling and asynchronous reset.
module tb_darktimer_nch;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic [3:0]  BE = 4'h0;
  logic [7:0]  ADDR = 8'h00;
  logic [31:0] DATAI = 32'h0;
  logic [31:0] DATAO;
  logic        RACK;
  logic        IRQ;
  logic [3:0]  IRQV;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  darktimer_nch #(.NCH(4), .WIDTH(32), .PRESCALE(49), .AW(8)) dut (
    .CLK(CLK), .RES(RES), .RD(RD), .WR(WR), .BE(BE), .ADDR(ADDR),
    .DATAI(DATAI), .DATAO(DATAO), .RACK(RACK), .IRQ(IRQ), .IRQV(IRQV)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    ADDR = a; DATAI = d; BE = 4'hF; WR = 1'b1;
    step(1);
    WR = 1'b0; BE = 4'h0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    ADDR = a; RD = 1'b1;
    step(1);
    RD = 1'b0;
    check_output("rack", {31'b0, RACK}, 32'd1);
    d = DATAO;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check_output(tag, d, exp);
  endtask

  // Waits for IRQV[2] to be high, bounded; returns the cycle stamp of detection.
  task automatic wait_irqv2(input string tag, output int stamp);
    bit got;
    got = 1'b0;
    stamp = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      step(1);
      if (IRQV[2]) begin
        got = 1'b1;
        stamp = cyc;
      end
    end
    check_output(tag, {31'b0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int t1, t2;

    $display("[TB] starting darktimer_nch bench");
    step(3);
    RES = 1'b1;
    check_output("rst_datao", DATAO, 32'd0);
    check_output("rst_rack", {31'b0, RACK}, 32'd0);
    check_output("rst_irq", {31'b0, IRQ}, 32'd0);
    check_output("rst_irqv", 32'(IRQV), 32'd0);

    read_check("rst_presc", 8'h04, 32'd49);
    read_check("rst_ctrl0", 8'h10, 32'd0);
    read_check("rst_reload0", 8'h14, 32'd0);
    read_check("rst_count0", 8'h18, 32'd0);
    step(1);
    check_output("rack_low", {31'b0, RACK}, 32'd0);
    read_check("reserved0", 8'h1C, 32'd0);
    read_check("absent_ch4", 8'h50, 32'd0);
    read_check("unmapped", 8'h60, 32'd0);
`ifdef DARKTIMER_TSTAMP_EN
    bus_read(8'h08, d);
    check_output("ts_lo_nonzero", {31'b0, d != 32'd0}, 32'd1);
    read_check("ts_hi", 8'h0C, 32'd0);
`else
    read_check("ts_lo_absent", 8'h08, 32'd0);
    read_check("ts_hi_absent", 8'h0C, 32'd0);
`endif

    // Periodic channel 0, RELOAD=3, tick every cycle.
    bus_write(8'h04, 32'd0);
    step(60);
    bus_write(8'h14, 32'd3);
    bus_write(8'h10, 32'h7);
    read_check("cnt_3", 8'h18, 32'd3);
    read_check("cnt_2", 8'h18, 32'd2);
    read_check("cnt_1", 8'h18, 32'd1);
    read_check("cnt_0", 8'h18, 32'd0);
    check_output("irq_lag", {31'b0, IRQ}, 32'd0);
    read_check("status_ev1", 8'h00, 32'h01);
    check_output("irq_set", {31'b0, IRQ}, 32'd1);
    read_check("cnt_reload", 8'h18, 32'd2);
    read_check("status_hold1", 8'h00, 32'h01);
    read_check("status_hold2", 8'h00, 32'h01);
    read_check("status_ovr", 8'h00, 32'h0101);
    bus_write(8'h10, 32'h0);
    read_check("cnt_frozen", 8'h18, 32'd2);
    read_check("ctrl_off", 8'h10, 32'd0);
    bus_write(8'h00, 32'h1);
    read_check("status_ack", 8'h00, 32'd0);
    check_output("irq_clear", {31'b0, IRQ}, 32'd0);

    // One-shot channel 1, RELOAD=2.
    bus_write(8'h24, 32'd2);
    bus_write(8'h20, 32'h5);
    step(6);
    read_check("os_status", 8'h00, 32'h02);
    read_check("os_ctrl", 8'h20, 32'h4);
    check_output("os_irq", {31'b0, IRQ}, 32'd1);
    check_output("os_irqv", 32'(IRQV), 32'h2);
    read_check("os_count", 8'h28, 32'd0);
    bus_write(8'h00, 32'h2);
    step(1);
    check_output("os_irq_clr", {31'b0, IRQ}, 32'd0);
    step(10);
    read_check("os_no_more", 8'h00, 32'd0);

    // Channel 0 periodic with RELOAD=0: an event on every tick.
    bus_write(8'h14, 32'd0);
    bus_write(8'h10, 32'h3);
    step(2);
    read_check("r0_ovr", 8'h00, 32'h0101);
    bus_write(8'h00, 32'h1);
    read_check("ack_vs_evt", 8'h00, 32'h0001);
    bus_write(8'h10, 32'h0);
    bus_write(8'h00, 32'h1);
    read_check("r0_cleared", 8'h00, 32'd0);
    check_output("r0_irq", {31'b0, IRQ}, 32'd0);

    // PRESC=9, channel 2 RELOAD=1 periodic: events 20 cycles apart.
    bus_write(8'h04, 32'd9);
    bus_write(8'h34, 32'd1);
    bus_write(8'h30, 32'h7);
    wait_irqv2("ch2_ev1_seen", t1);
    bus_write(8'h00, 32'h4);
    step(1);
    check_output("ch2_irqv_clr", 32'(IRQV), 32'd0);
    wait_irqv2("ch2_ev2_seen", t2);
    check_output("ch2_spacing", 32'(t2 - t1), 32'd20);
    check_output("ch2_irq", {31'b0, IRQ}, 32'd1);

    // Asynchronous reset mid-count.
    step(5);
    RES = 1'b0;
    #2;
    check_output("async_irq", {31'b0, IRQ}, 32'd0);
    check_output("async_irqv", 32'(IRQV), 32'd0);
    check_output("async_datao", DATAO, 32'd0);
    step(2);
    RES = 1'b1;
    read_check("rr_presc", 8'h04, 32'd49);
    read_check("rr_ctrl2", 8'h30, 32'd0);
    read_check("rr_reload2", 8'h34, 32'd0);
    read_check("rr_count2", 8'h38, 32'd0);
    read_check("rr_status", 8'h00, 32'd0);
    check_output("rr_irq", {31'b0, IRQ}, 32'd0);

    // Simultaneous RD and WR: read returns the pre-write value.
    ADDR = 8'h04; DATAI = 32'd7; BE = 4'hF; WR = 1'b1; RD = 1'b1;
    step(1);
    WR = 1'b0; RD = 1'b0; BE = 4'h0;
    check_output("rdwr_old", DATAO, 32'd49);
    read_check("rdwr_new", 8'h04, 32'd7);
    bus_write(8'h1C, 32'hFFFF_FFFF);
    bus_write(8'h18, 32'h1234);
    read_check("ro_count", 8'h18, 32'd0);
    read_check("rsvd_write", 8'h1C, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
